serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial unsigned adder: the sequential stage built around half_adder.
//   Accepts two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock.
//   Each bit goes through one full-adder cell (two half_adder instances plus an OR gate).
//   The carry is held in a register between cycles.
//   Returns sum and carry_out with a one-cycle done pulse; used where area matters more than latency.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//   clk        input   1      single clock, rising-edge
//   rst_n      input   1      asynchronous, active-low reset
//   start      input   1      request; sampled only in IDLE
//   a          input   WIDTH  operand A, captured on accepted start
//   b          input   WIDTH  operand B, captured on accepted start
//   busy       output  1      high in RUN and DONE
//   done       output  1      one-cycle pulse: sum/carry_out valid
//   sum        output  WIDTH  (a+b) mod 2**WIDTH
//   carry_out  output  1      bit WIDTH of a+b
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, sum=0, carry_out=0; shift regs, carry reg and counter = 0.
//     rst_n low mid-operation aborts immediately; no done is produced for the aborted op.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: on start=1 at edge E, latch a/b into shift regs, clear carry reg and bit counter, go to RUN.
//     RUN: at edges E+1 .. E+WIDTH, process bit i = counter value.
//       full_adder(a_sr[0], b_sr[0], carry_q) produces s and co.
//       carry_q <= co; a_sr and b_sr shift right.
//       res_sr <= {s, res_sr[WIDTH-1:1]}; counter++.
//     At edge E+WIDTH (last bit) go to DONE.
//       Register sum <= final res_sr (including the last bit) and carry_out <= final co.
//       done <= 1.
//     DONE: lasts exactly one cycle. At the next edge done <= 0 and state returns to IDLE.
//   - Latency: done is high during the cycle after edge E+WIDTH. Throughput: one op per WIDTH+2 cycles.
//   - start is ignored in RUN and DONE. No queuing; a, b and start changes have no effect on the op in flight.
//   - If start is held high continuously, the next op is accepted at the first edge in IDLE after DONE.
//   - sum/carry_out change only at the DONE transition. Between done pulses they hold the last result,
//     including while a new op runs.
//   - Counter width is $clog2(WIDTH+1). There is no wrap-around: the counter never exceeds WIDTH.
//   - WIDTH=1: RUN lasts one cycle; behaviour is otherwise identical.
// STRUCTURE
//   - serial_adder_pkg holds the state typedef: enum logic [1:0] {S_IDLE, S_RUN, S_DONE}.
//   - Sub-module full_adder (a, b, cin -> sum, cout) is built from two half_adder instances
//     and an OR of their carries. It is the only combinational datapath in the block.
//   - The top level contains the FSM, counter, operand/result shift registers and the carry register.
// TESTING
//   1. Reset: hold rst_n=0 -> busy=0, done=0, sum=0, carry_out=0. Release it; start=0 -> no activity.
//   2. WIDTH=8, a=8'h0F, b=8'h01, pulse start -> done exactly 8 cycles after the start edge, one cycle wide.
//      Result: sum=8'h10, carry_out=0.
//   3. a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1 (carry ripples through every bit).
//      a=8'hFF, b=8'hFF -> sum=8'hFE, carry_out=1.
//   4. Start a=8'h12, b=8'h34, then drive start=1 with a=8'hAA, b=8'h55 during RUN.
//      -> exactly one done, with sum=8'h46, carry_out=0.
//   5. Drive rst_n=0 at bit 4 of a=8'h80, b=8'h80 -> outputs 0 immediately and no done.
//      Rerun the same op -> sum=8'h00, carry_out=1.
//   6. WIDTH=4, start held high: exhaustively check all 256 (a,b) pairs back-to-back.
//      {carry_out,sum} must equal a+b; consecutive done pulses are exactly 6 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  // Operation sequencing: accept operands, run one bit per clock, then present the result.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders plus an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s1),
    .carry(c1)
  );

  half_adder u_ha1 (
    .a    (s1),
    .b    (cin),
    .sum  (sum),
    .carry(c2)
  );

  // Both half adders can never carry at once, so OR is sufficient.
  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell with a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             done_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry_q),
    .sum (fa_s),
    .cout(fa_co)
  );

  // Result shift register input: new bit enters at the MSB so bit 0 lands at index 0 at the end.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = fa_s;
  end else begin : g_res_wn
    assign res_next = {fa_s, res_sr[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == LastBit);

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= fa_co;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            // Publish the result including the bit computed this cycle.
            sum_q       <= res_next;
            carry_out_q <= fa_co;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=4 instances against a plain a+b model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       carry8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       carry4;

  int n_checks = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .carry_out(carry8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .busy     (busy4),
    .done     (done4),
    .sum      (sum4),
    .carry_out(carry4)
  );

  // Drive one WIDTH=8 op; lat = negedges from the start edge until done is seen (40 = timeout).
  task automatic run8(input logic [7:0] ra, input logic [7:0] rb,
                      output logic [8:0] res, output int lat);
    @(negedge clk);
    a8 = ra;
    b8 = rb;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {carry8, sum8};
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic active;
    rst_n = 1'b0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, carry8, sum8} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_w8: got busy=%b done=%b carry=%b sum=%h, want all 0",
               busy8, done8, carry8, sum8);
    end
    n_checks++;
    if ({busy4, done4, carry4, sum4} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_w4: got busy=%b done=%b carry=%b sum=%h, want all 0",
               busy4, done4, carry4, sum4);
    end
    rst_n = 1'b1;
    active = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy8 || done8 || busy4 || done4) active = 1'b1;
    end
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got activity=%b, want 0", active);
    end
  endtask

  task automatic test_basic;
    int k;
    @(negedge clk);
    a8 = 8'h0F;
    b8 = 8'h01;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_run: got %b, want 1", busy8);
    end
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL latency_basic: got %0d cycles, want 8", k);
    end
    n_checks++;
    if ({carry8, sum8} !== 9'h010) begin
      n_fail++;
      $display("FAIL sum_0f_01: got %h, want 010", {carry8, sum8});
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_carry;
    logic [8:0] res;
    int lat;
    run8(8'hFF, 8'h01, res, lat);
    n_checks++;
    if (res !== 9'h100 || lat != 8) begin
      n_fail++;
      $display("FAIL carry_ff_01: got %h lat %0d, want 100 lat 8", res, lat);
    end
    run8(8'hFF, 8'hFF, res, lat);
    n_checks++;
    if (res !== 9'h1FE || lat != 8) begin
      n_fail++;
      $display("FAIL carry_ff_ff: got %h lat %0d, want 1fe lat 8", res, lat);
    end
  endtask

  task automatic test_random;
    logic [8:0] res;
    logic [8:0] exp;
    logic [7:0] ra;
    logic [7:0] rb;
    int lat;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      exp = {1'b0, ra} + {1'b0, rb};
      run8(ra, rb, res, lat);
      n_checks++;
      if (res !== exp || lat != 8) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h got %h lat %0d, want %h lat 8",
                 i, ra, rb, res, lat, exp);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [8:0] res;
    logic [8:0] got;
    int lat;
    int n_done;
    int at;
    run8(8'h01, 8'h02, res, lat);
    @(negedge clk);
    a8 = 8'h12;
    b8 = 8'h34;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    at = -1;
    got = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin
        n_done++;
        at = k;
        got = {carry8, sum8};
      end
      if (k == 3) begin
        n_checks++;
        if ({carry8, sum8} !== 9'h003) begin
          n_fail++;
          $display("FAIL hold_during_run: got %h, want 003", {carry8, sum8});
        end
      end
      if (k == 1) begin
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
      end
      if (k == 6) start8 = 1'b0;
    end
    n_checks++;
    if (n_done != 1 || at != 8) begin
      n_fail++;
      $display("FAIL start_in_run_dones: got %0d dones at %0d, want 1 at 8", n_done, at);
    end
    n_checks++;
    if (got !== 9'h046) begin
      n_fail++;
      $display("FAIL start_in_run_sum: got %h, want 046", got);
    end
  endtask

  task automatic test_abort;
    logic [8:0] res;
    int lat;
    int n_done;
    @(negedge clk);
    a8 = 8'h80;
    b8 = 8'h80;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, carry8, sum8} !== 11'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b carry=%b sum=%h, want all 0",
               busy8, done8, carry8, sum8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", n_done);
    end
    run8(8'h80, 8'h80, res, lat);
    n_checks++;
    if (res !== 9'h100 || lat != 8) begin
      n_fail++;
      $display("FAIL rerun_80_80: got %h lat %0d, want 100 lat 8", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] pair;
    logic [7:0] idx;
    logic [4:0] exp;
    int off;
    int n;
    int cyc;
    int last;
    int bad_sum;
    int bad_gap;
    off = int'($urandom_range(0, 255));
    bad_sum = 0;
    bad_gap = 0;
    @(negedge clk);
    idx = 8'(off);
    a4 = idx[7:4];
    b4 = idx[3:0];
    start4 = 1'b1;
    q.push_back(idx);
    n = 0;
    cyc = 0;
    last = -1;
    while (n < 256 && cyc < 256 * 6 + 50) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        pair = q.pop_front();
        exp = {1'b0, pair[7:4]} + {1'b0, pair[3:0]};
        n_checks++;
        if ({carry4, sum4} !== exp) begin
          n_fail++;
          bad_sum++;
          if (bad_sum <= 5)
            $display("FAIL b2b_sum: %h+%h got %h, want %h",
                     pair[7:4], pair[3:0], {carry4, sum4}, exp);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 6) begin
            n_fail++;
            bad_gap++;
            if (bad_gap <= 5)
              $display("FAIL b2b_gap: got %0d cycles between dones, want 6", cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n < 256) begin
          idx = 8'(n + off);
          a4 = idx[7:4];
          b4 = idx[3:0];
          q.push_back(idx);
        end
      end
    end
    start4 = 1'b0;
    n_checks++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want 256", n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
